// File: rtl/key_decoder.sv
// ---------------------------------------------------------------------------
// key_decoder
//
// PS/2 keyboard receiver and arrow-key state tracker.
//
// The raw PS/2 clock and data lines are synchronised into the pclk domain.
// Bits are sampled on each falling ps2 clock edge and framed as start(0),
// d0..d7 LSB first, odd parity, stop(1). Good bytes are presented on
// scan_code with a one-cycle scan_valid pulse. Bad parity, a bad stop bit or
// a stalled frame gives a one-cycle frame_err pulse instead. A small prefix
// FSM (E0 / F0 / E0 F0) turns the byte stream into make/break events for
// the four arrow keys, held on the key vector.
//
// Optional feature (compile-time macro KEY_WASD_EN): the plain codes for
// W, S, A and D drive the same four key bits as up, down, left and right.
// Arrow and WASD holds are tracked separately and ORed together. Without
// the macro, plain codes never touch key.
//
// Parameters:
//   TIMEOUT_CYC  max pclk cycles between ps2 falling edges inside a frame
//
// Ports:
//   pclk        in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock (asynchronous)
//   ps2_data    in   raw PS/2 data  (asynchronous)
//   key         out  [3:0] held keys: 0 up, 1 down, 2 left, 3 right
//   scan_code   out  [7:0] last correctly received byte
//   scan_valid  out  one-cycle pulse when scan_code updates
//   frame_err   out  one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module key_decoder #(
    parameter int TIMEOUT_CYC = 65000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1) + 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic { RX_IDLE, RX_BUSY } rx_state_t;
    typedef enum logic [1:0] { D_IDLE, D_EXT, D_BRK, D_EXT_BRK } dec_state_t;

    // Bit counter saturates at 11 (start + 8 data + parity + stop).
    function automatic logic [3:0] bit_inc(input logic [3:0] c);
        return (c == 4'd11) ? c : c + 4'd1;
    endfunction

    // Apply a make (set) or break (clear) for an extended arrow code.
    function automatic logic [3:0] arrow_apply(input logic [3:0] cur,
                                               input logic [7:0] code,
                                               input logic       make);
        logic [3:0] r;
        r = cur;
        case (code)
            8'h75:   r[0] = make;
            8'h72:   r[1] = make;
            8'h6B:   r[2] = make;
            8'h74:   r[3] = make;
            default: r = cur;
        endcase
        return r;
    endfunction

    // ---- stage p0..p2: two-flop synchronisers plus previous ps2 clock ----
    logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic ps2_data_p0, ps2_data_p1;
    logic fall_p1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_clk_p2  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_clk_p2  <= ps2_clk_p1;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    assign fall_p1 = ps2_clk_p2 & ~ps2_clk_p1;

    // ---- receiver: frame assembly, checking and timeout ----
    rx_state_t       rx_state;
    logic [3:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      shreg;
    logic            par_bit;

    // Payload shift register and parity carry no control meaning, so they
    // are left out of reset.
    always_ff @(posedge pclk) begin
        if (rx_state == RX_BUSY && fall_p1) begin
            if (bit_cnt < 4'd9)
                shreg <= {ps2_data_p1, shreg[7:1]};
            else if (bit_cnt == 4'd9)
                par_bit <= ps2_data_p1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= 4'd0;
            to_cnt     <= '0;
            scan_code  <= 8'h00;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    to_cnt  <= '0;
                    bit_cnt <= 4'd0;
                    // A start bit sampled high is noise; stay idle silently.
                    if (fall_p1 && !ps2_data_p1) begin
                        rx_state <= RX_BUSY;
                        bit_cnt  <= 4'd1;
                    end
                end
                RX_BUSY: begin
                    if (fall_p1) begin
                        to_cnt  <= '0;
                        bit_cnt <= bit_inc(bit_cnt);
                        if (bit_cnt == 4'd10) begin
                            // Stop bit: data plus parity must hold an odd
                            // number of ones and stop must be high.
                            rx_state <= RX_IDLE;
                            bit_cnt  <= 4'd0;
                            if (ps2_data_p1 && (^{shreg, par_bit})) begin
                                scan_code  <= shreg;
                                scan_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (to_cnt >= TO_LIM) begin
                        rx_state  <= RX_IDLE;
                        bit_cnt   <= 4'd0;
                        to_cnt    <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---- decoder: prefix FSM and arrow-key holds ----
    dec_state_t dec_state;
    logic [3:0] key_arrow;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= D_IDLE;
            key_arrow <= 4'b0000;
        end else if (frame_err) begin
            dec_state <= D_IDLE;
        end else if (scan_valid) begin
            case (dec_state)
                D_IDLE: begin
                    if (scan_code == CODE_EXT)
                        dec_state <= D_EXT;
                    else if (scan_code == CODE_BRK)
                        dec_state <= D_BRK;
                    else
                        dec_state <= D_IDLE;
                end
                D_EXT: begin
                    if (scan_code == CODE_BRK) begin
                        dec_state <= D_EXT_BRK;
                    end else begin
                        key_arrow <= arrow_apply(key_arrow, scan_code, 1'b1);
                        dec_state <= D_IDLE;
                    end
                end
                D_EXT_BRK: begin
                    key_arrow <= arrow_apply(key_arrow, scan_code, 1'b0);
                    dec_state <= D_IDLE;
                end
                D_BRK:   dec_state <= D_IDLE;
                default: dec_state <= D_IDLE;
            endcase
        end
    end

`ifdef KEY_WASD_EN
    // Plain make arrives in IDLE (any byte but the two prefixes); plain
    // break arrives in BRK. Both use the same state the arrow FSM reads.
    logic [3:0] key_wasd;
    logic       plain_make, plain_brk;

    function automatic logic [3:0] wasd_apply(input logic [3:0] cur,
                                              input logic [7:0] code,
                                              input logic       make);
        logic [3:0] r;
        r = cur;
        case (code)
            8'h1D:   r[0] = make;
            8'h1B:   r[1] = make;
            8'h1C:   r[2] = make;
            8'h23:   r[3] = make;
            default: r = cur;
        endcase
        return r;
    endfunction

    assign plain_make = scan_valid && (dec_state == D_IDLE) &&
                        (scan_code != CODE_EXT) && (scan_code != CODE_BRK);
    assign plain_brk  = scan_valid && (dec_state == D_BRK);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            key_wasd <= 4'b0000;
        else if (plain_make)
            key_wasd <= wasd_apply(key_wasd, scan_code, 1'b1);
        else if (plain_brk)
            key_wasd <= wasd_apply(key_wasd, scan_code, 1'b0);
    end

    assign key = key_arrow | key_wasd;
`else
    assign key = key_arrow;
`endif

endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 pclk  input  1  system clock; all state is clocked on its rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 ps2_clk  input  1  raw PS/2 keyboard clock, asynchronous to pclk.
REQ-004 ps2_data  input  1  raw PS/2 keyboard data, asynchronous to pclk.
REQ-005 key  output  4  held-key vector: bit0 up, bit1 down, bit2 left, bit3 right; 1 means held.
REQ-006 scan_code  output  8  last correctly received byte.
REQ-007 scan_valid  output  1  one-cycle pulse when scan_code updates.
REQ-008 frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
REQ-009 Parameter TIMEOUT_CYC, default 65000 (about 1 ms at 65 MHz), is the maximum number of pclk cycles allowed between ps2 falling edges inside one frame.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is detected when the synchronized clock's previous value is 1 and its current value is 0.
REQ-011 The receiver SHALL sample the synchronized ps2_data on each detected falling edge, with frame order start(0), d0..d7 LSB first, odd parity, stop(1).
REQ-012 A start bit sampled as 1 SHALL be ignored: the receiver stays idle, and no error is flagged.
REQ-013 A frame with odd parity and stop=1 SHALL pulse scan_valid for one cycle, in the cycle after the stop-bit edge is detected, with scan_code updated in that same cycle.
REQ-014 A frame with bad parity or stop=0 SHALL pulse frame_err, SHALL leave scan_code unchanged, and SHALL return the receiver to idle.
REQ-015 The bit counter SHALL saturate at 11 bits; exceeding TIMEOUT_CYC cycles since the last falling edge mid-frame SHALL abort the frame, pulse frame_err and return the receiver to idle.
REQ-016 Decoder FSM states SHALL be IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-017 Decoder transitions:
- IDLE: E0 goes to EXT, F0 goes to BRK, any other byte is processed as a plain code.
- EXT: F0 goes to EXT_BRK, any other byte is processed as an extended make, then IDLE.
- EXT_BRK: any byte is processed as an extended break, then IDLE.
- BRK: any byte is processed as a plain break, then IDLE.
REQ-018 Extended codes 75, 72, 6B and 74 SHALL map to key bits 0, 1, 2 and 3 respectively; a make sets the bit and a break clears it.
REQ-019 A key bit SHALL update in the cycle after scan_valid for its final byte.
REQ-020 Unmapped codes, including E1 sequences, SHALL leave key unchanged.
REQ-021 Typematic repeat makes for an already-set bit SHALL cause no change.
REQ-022 Simultaneous keys SHALL be held independently, so several key bits may be 1 at once.
REQ-023 A frame_err SHALL return the decoder FSM to IDLE and leave key unchanged.

Reset
REQ-024 While rst_n=0, the block SHALL hold key=0, scan_code=0, scan_valid=0 and frame_err=0, with receiver and decoder in IDLE, counters at 0, and synchronizer flops at 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, decoding SHALL resume at the next valid start bit.

Configuration
REQ-026 With macro KEY_WASD_EN defined, plain (non-E0) codes 1D (W), 1B (S), 1C (A) and 23 (D) SHALL additionally set or clear bits 0, 1, 2 and 3 respectively.
REQ-027 A key bit SHALL be the OR of its arrow and WASD sources, each tracked separately.
REQ-028 Without KEY_WASD_EN, plain codes SHALL never affect key, and no WASD tracking logic SHALL be present.

Verification
REQ-029 Send E0 75 -> key=0001; then send E0 F0 75 -> key=0000; scan_valid pulses once per byte.
REQ-030 Send E0 6B then E0 74 -> key=1100; then send E0 F0 6B -> key=1000.
REQ-031 Send byte 75 with even parity -> frame_err pulses, scan_code is unchanged, key is unchanged, and the next E0 75 yields key=0001.
REQ-032 Send 6 bits, then idle for TIMEOUT_CYC+10 cycles -> frame_err pulses once; a following full frame E0, 72 yields key=0010.
REQ-033 Assert rst_n=0 after bit 4 of a frame with key=0101 -> key=0000 immediately; after release, E0 74 yields key=1000.
REQ-034 With KEY_WASD_EN, send 1D then E0 75 then F0 1D -> key=0001 throughout; without the macro, 1D -> key=0000.
